// File: rtl/demux4_32_buf.sv
// demux4_32_buf
// Buffered 1-to-4 demultiplexer. Each accepted input word is steered to the
// channel named by in_select and held in that channel's one-entry slot until
// its consumer takes it. Outputs come straight from flops, so nothing on the
// input side reaches out_data/out_valid in the same cycle.
//
// Per-channel slot occupancy (not an FSM beyond this bit):
//   state | meaning
//   EMPTY | full_q[i]=0, slot may hold a stale word, out_valid[i]=0
//   FULL  | full_q[i]=1, slot holds an undelivered word, out_valid[i]=1
module demux4_32_buf #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_select,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [CNTW-1:0]  xfer_cnt
);

    logic [3:0]       full_q;
    logic [3:0]       full_d;
    logic [WIDTH-1:0] slot_q [4];
    logic [WIDTH-1:0] slot_d [4];
    logic [CNTW-1:0]  xfer_cnt_q;
    logic [CNTW-1:0]  xfer_cnt_d;

    logic             push;
    logic [3:0]       push_vec;
    logic [3:0]       pop;

    // Acceptance: the selected slot is free, or it is being drained this cycle.
    // Deliberately independent of in_valid so the producer can look before it leaps.
    always_comb begin
        in_ready = ~full_q[in_select] | out_ready[in_select];
        push     = in_valid & in_ready;
    end

    // Decode push target and per-channel pops.
    always_comb begin
        push_vec = '0;
        if (push) begin
            push_vec[in_select] = 1'b1;
        end
        pop = full_q & out_ready;
    end

    // Next state for slots, occupancy and the transfer counter.
    // A push wins over a pop on the same channel: the slot is refilled and stays full.
    always_comb begin
        full_d     = full_q;
        xfer_cnt_d = xfer_cnt_q;
        for (int i = 0; i < 4; i++) begin
            slot_d[i] = slot_q[i];
            if (push_vec[i]) begin
                slot_d[i] = in_data;
                full_d[i] = 1'b1;
            end else if (pop[i]) begin
                full_d[i] = 1'b0;
            end
        end
        if (push) begin
            xfer_cnt_d = xfer_cnt_q + CNTW'(1);
        end
    end

    // State registers; reset discards any buffered words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q     <= '0;
            xfer_cnt_q <= '0;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            full_q     <= full_d;
            xfer_cnt_q <= xfer_cnt_d;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    // Registered outputs.
    always_comb begin
        out_valid = full_q;
        out_data0 = slot_q[0];
        out_data1 = slot_q[1];
        out_data2 = slot_q[2];
        out_data3 = slot_q[3];
        xfer_cnt  = xfer_cnt_q;
    end

endmodule

// File: tb/tb_demux4_32_buf.sv
// Testbench for demux4_32_buf: directed scenarios plus randomized traffic,
// checked against a queue-per-channel reference model. A second instance with
// a 4-bit counter shares the stimulus to exercise counter wrap.
module tb_demux4_32_buf;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic [1:0]    in_select;
    logic [3:0]    out_ready;

    logic          in_ready;
    logic [3:0]    out_valid;
    logic [W-1:0]  out_data0, out_data1, out_data2, out_data3;
    logic [15:0]   xfer_cnt;

    logic          in_ready4;
    logic [3:0]    out_valid4;
    logic [W-1:0]  out4_d0, out4_d1, out4_d2, out4_d3;
    logic [3:0]    xfer_cnt4;

    always #5 clk = ~clk;

    demux4_32_buf #(.WIDTH(32), .CNTW(16)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_select(in_select),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
        .xfer_cnt(xfer_cnt)
    );

    demux4_32_buf #(.WIDTH(32), .CNTW(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_select(in_select),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_data0(out4_d0), .out_data1(out4_d1), .out_data2(out4_d2), .out_data3(out4_d3),
        .xfer_cnt(xfer_cnt4)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: each channel is a queue of undelivered words (capacity 1),
    // plus the last word written into it (what the slot shows after a pop).
    logic [W-1:0] mq [4][$];
    logic [W-1:0] held [4];
    int unsigned  accepted;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] dut_data(input int i);
        case (i)
            0: return out_data0;
            1: return out_data1;
            2: return out_data2;
            default: return out_data3;
        endcase
    endfunction

    function automatic logic [W-1:0] dut4_data(input int i);
        case (i)
            0: return out4_d0;
            1: return out4_d1;
            2: return out4_d2;
            default: return out4_d3;
        endcase
    endfunction

    function automatic logic model_ready(input logic [1:0] s);
        return (mq[s].size() == 0) || out_ready[s];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            held[i] = '0;
        end
        accepted = 0;
    endtask

    task automatic check_outputs();
        logic [3:0] ev;
        for (int i = 0; i < 4; i++) begin
            ev[i] = (mq[i].size() != 0);
            chk_eq($sformatf("out_data%0d", i), dut_data(i), held[i]);
            chk_eq($sformatf("out4_data%0d", i), dut4_data(i), held[i]);
        end
        chk_eq("out_valid", out_valid, ev);
        chk_eq("out_valid4", out_valid4, ev);
        chk_eq("xfer_cnt", xfer_cnt, accepted % 65536);
        chk_eq("xfer_cnt4", xfer_cnt4, accepted % 16);
    endtask

    // One clock with the inputs currently driven (set just after a negedge).
    task automatic cycle();
        logic push;
        logic [3:0] popv;
        #1;
        chk_eq("in_ready", in_ready, model_ready(in_select));
        chk_eq("in_ready4", in_ready4, model_ready(in_select));
        push = in_valid && model_ready(in_select);
        for (int i = 0; i < 4; i++) popv[i] = out_ready[i] && (mq[i].size() != 0);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (popv[i]) void'(mq[i].pop_front());
        end
        if (push) begin
            mq[in_select].push_back(in_data);
            held[in_select] = in_data;
            accepted++;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_select = '0;
        out_ready = '0;
        model_clear();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d, input logic [3:0] r);
        in_valid  = v;
        in_select = s;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        logic [W-1:0] words [8];
        logic         hold;

        do_reset();

        // Reset mid-stream with channels 0,1,3 full.
        drive(1, 0, 32'hA0, 4'h0); cycle();
        drive(1, 1, 32'hA1, 4'h0); cycle();
        drive(1, 3, 32'hA3, 4'h0); cycle();
        chk_eq("pre_reset_valid", out_valid, 4'b1011);
        drive(0, 0, 0, 4'h0);
        #2 reset_n = 1'b0;
        #1;
        chk_eq("async_rst_valid", out_valid, 4'b0000);
        chk_eq("async_rst_cnt", xfer_cnt, 16'd0);
        chk_eq("async_rst_d0", out_data0, 32'h0);
        chk_eq("async_rst_d1", out_data1, 32'h0);
        chk_eq("async_rst_d3", out_data3, 32'h0);
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        check_outputs();

        // Basic route.
        drive(1, 2, 32'hDEADBEEF, 4'h0); cycle();
        chk_eq("route_valid", out_valid, 4'b0100);
        chk_eq("route_data2", out_data2, 32'hDEADBEEF);
        chk_eq("route_cnt", xfer_cnt, 16'd1);

        // Backpressure on channel 1, channel 3 still open.
        drive(1, 1, 32'h1111_0001, 4'h0); cycle();
        drive(1, 1, 32'h1111_0002, 4'h0);
        #1 chk_eq("bp_ready_sel1", in_ready, 1'b0);
        in_select = 2'd3;
        in_data   = 32'h3333_0003;
        cycle();
        chk_eq("bp_slot1_kept", out_data1, 32'h1111_0001);
        chk_eq("bp_sel3_taken", out_data3, 32'h3333_0003);

        // Pass-through: full channel 0 draining while refilled.
        do_reset();
        drive(1, 0, 32'h1, 4'h0); cycle();
        drive(1, 0, 32'h2, 4'h1);
        #1 chk_eq("pt_ready", in_ready, 1'b1);
        cycle();
        chk_eq("pt_valid0", out_valid[0], 1'b1);
        chk_eq("pt_data0", out_data0, 32'h2);
        drive(0, 0, 0, 4'h1); cycle();
        chk_eq("pt_popped", out_valid[0], 1'b0);

        // Streaming 8 words cyclic, all consumers ready.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            words[k] = $urandom;
            drive(1, 2'(k % 4), words[k], 4'hF);
            #1 chk_eq("stream_ready", in_ready, 1'b1);
            cycle();
            chk_eq("stream_word", dut_data(k % 4), words[k]);
            chk_eq("stream_valid", out_valid[k % 4], 1'b1);
        end
        drive(0, 0, 0, 4'hF); cycle();
        chk_eq("stream_drained", out_valid, 4'h0);

        // Counter wrap on the 4-bit instance.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            drive(1, 2'(k % 4), 32'(k), 4'hF); cycle();
        end
        chk_eq("wrap_cnt4", xfer_cnt4, 4'd1);
        chk_eq("wrap_cnt16", xfer_cnt, 16'd17);

        // Randomized traffic obeying the producer hold rule.
        do_reset();
        hold = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (!hold) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_select = 2'($urandom_range(0, 3));
                in_data   = $urandom;
            end
            out_ready = 4'($urandom);
            #1 hold = in_valid && !model_ready(in_select);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
